pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Owns the architectural program counter and the fetch handshake to instruction memory.
- Sits directly downstream of the 64-bit next-PC select mux: the mux output (PC+4, branch or jump target, selected by the decode/execute select lines) drives next_pc.
- Registers it into PC, issues a request/grant/response fetch, and presents the fetched instruction with its PC to decode.
- Handles stall, redirect (flush) and misaligned-target trapping.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.
- XLEN, 64, PC and address width.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- next_pc  input  XLEN  next PC from the select mux; sampled only when PC advances
- stall  input  1  decode not ready; holds the presented instruction
- flush  input  1  redirect request; has priority over everything except reset
- flush_pc  input  XLEN  redirect target
- imem_req  output  1  fetch request valid
- imem_addr  output  XLEN  fetch address; always equal to pc
- imem_gnt  input  1  memory accepted request (same cycle as imem_req)
- imem_rvalid  input  1  response valid, at least 1 cycle after grant
- imem_rdata  input  32  instruction word
- instr_valid  output  1  instr/instr_pc valid for decode
- instr  output  32  fetched instruction
- instr_pc  output  XLEN  PC of instr
- pc  output  XLEN  current PC register
- misaligned  output  1  sticky trap flag: a loaded PC violated alignment

Behaviour:
- Reset (async, reset_n=0), effective immediately:
  - pc=RESET_PC, state=REQ, imem_req=0
  - instr_valid=0, instr=0, instr_pc=0, misaligned=0
- imem_req is combinational (state==REQ).
- States:
  - REQ: imem_req=1. If imem_gnt -> WAIT; else stay.
  - WAIT: on imem_rvalid, latch instr=imem_rdata and instr_pc=pc, set instr_valid=1, -> HOLD. Zero-cycle responses are not supported.
  - HOLD: instr_valid=1. If stall, stay with outputs frozen. If !stall, pc<=next_pc, instr_valid<=0, -> REQ.
    - Net: one instruction per (grant latency + response latency + 1) cycles.
  - DRAIN: a response is still outstanding after a flush. On imem_rvalid, discard the data -> REQ. imem_req=0.
  - TRAP: imem_req=0, instr_valid=0; stays until flush.
- Alignment check, applied to any value about to be loaded into pc (next_pc or flush_pc):
  - Misaligned means bits [1:0]!=0.
  - On a misaligned load: pc still takes the value, misaligned<=1, state -> TRAP.
  - misaligned clears only on a flush to an aligned target, or on reset.
- Flush (any state, sampled at clock edge):
  - Aligned flush_pc: pc<=flush_pc, instr_valid<=0.
  - Next state: DRAIN if in WAIT without rvalid this cycle, or if in REQ with gnt this cycle; otherwise REQ.
  - Flush while stall=1: flush wins and stall is ignored.
- Simultaneous cases:
  - flush with rvalid in WAIT: response discarded, -> REQ.
  - flush in DRAIN with rvalid: -> REQ. Flush in DRAIN without rvalid: stay in DRAIN with the new pc.
- next_pc is ignored outside the HOLD&&!stall cycle.
- Reset mid-transaction: state -> REQ, and memory is expected to reset alongside. No drain after reset.

Optional Feature:
- Macro RVC_ALIGN_EN.
- Defined: alignment check uses bit [0] only (2-byte alignment for compressed instructions). A pc with [1:0]=2'b10 is legal and fetched as-is; the full 32-bit word is returned and decode handles halves.
- Undefined: 4-byte alignment as above.

Test Plan:
- Reset with RESET_PC=64'h1000, gnt=1, rvalid 1 cycle later with rdata=32'h00000013, stall=0, next_pc=64'h1004:
  - imem_addr=64'h1000; instr=32'h13 and instr_pc=64'h1000 in HOLD
  - next request at 64'h1004 exactly 3 cycles after the first.
- Hold stall=1 for 5 cycles in HOLD:
  - instr, instr_pc and pc stable; no imem_req.
  - After release, pc=next_pc (64'h2000 from mux branch select) and imem_addr=64'h2000.
- Flush to 64'h3000 while in WAIT, with rvalid arriving 2 cycles later carrying 32'hDEADBEEF:
  - word discarded, instr_valid stays 0
  - next request at 64'h3000.
- next_pc=64'h1006 in HOLD:
  - misaligned=1, pc=64'h1006, imem_req stays 0.
  - With RVC_ALIGN_EN defined: no trap, request issued at 64'h1006.
- In TRAP, flush to 64'h4000:
  - misaligned clears, request at 64'h4000.
- Assert reset_n low during WAIT:
  - outputs immediately reset values
  - after release, first request at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC and the request/grant/response
// instruction-fetch handshake. It presents each fetched word and its PC to
// decode, and it handles stall, flush redirect and misaligned-target traps.
//
// Optional build macro: RVC_ALIGN_EN
//   - Defined:   targets need only 2-byte alignment (bit [0] must be 0).
//   - Undefined: targets need 4-byte alignment (bits [1:0] must be 0).
module pc_fetch_ctrl #(
  parameter int unsigned           XLEN     = 64,
  parameter logic [XLEN-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] next_pc,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc,
  output logic            misaligned
);

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_TRAP  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              r_instr_valid;
  logic              w_instr_valid_nxt;
  logic [31:0]       r_instr;
  logic [31:0]       w_instr_nxt;
  logic [XLEN-1:0]   r_instr_pc;
  logic [XLEN-1:0]   w_instr_pc_nxt;
  logic              r_misaligned;
  logic              w_misaligned_nxt;

  logic              w_next_pc_mis;
  logic              w_flush_pc_mis;
  logic              w_resp_pending;

  // Alignment check for the two possible sources of a new PC value.
`ifdef RVC_ALIGN_EN
  assign w_next_pc_mis  = next_pc[0];
  assign w_flush_pc_mis = flush_pc[0];
`else
  assign w_next_pc_mis  = |next_pc[1:0];
  assign w_flush_pc_mis = |flush_pc[1:0];
`endif

  // A response will still arrive after this edge: a granted request that
  // has not yet been answered, or a request being granted right now.
  assign w_resp_pending = ((r_state == ST_WAIT || r_state == ST_DRAIN) && !imem_rvalid)
                        || (r_state == ST_REQ && imem_gnt);

  // Request is withheld while reset is asserted, even though the state
  // register already sits in REQ.
  assign imem_req    = reset_n && (r_state == ST_REQ);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign misaligned  = r_misaligned;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath-next logic; flush overrides every state.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_misaligned_nxt  = r_misaligned;

    if (flush) begin
      w_pc_nxt          = flush_pc;
      w_instr_valid_nxt = 1'b0;
      if (w_flush_pc_mis) begin
        w_misaligned_nxt = 1'b1;
        w_state_nxt      = ST_TRAP;
      end else begin
        w_misaligned_nxt = 1'b0;
        w_state_nxt      = w_resp_pending ? ST_DRAIN : ST_REQ;
      end
    end else begin
      unique case (r_state)
        ST_REQ: begin
          if (imem_gnt) begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            w_instr_nxt       = imem_rdata;
            w_instr_pc_nxt    = r_pc;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_pc_nxt          = next_pc;
            w_instr_valid_nxt = 1'b0;
            if (w_next_pc_mis) begin
              w_misaligned_nxt = 1'b1;
              w_state_nxt      = ST_TRAP;
            end else begin
              w_state_nxt      = ST_REQ;
            end
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_TRAP: begin
          w_state_nxt = ST_TRAP;
        end
        default: begin
          w_state_nxt = ST_REQ;
        end
      endcase
    end
  end

  // Datapath registers: PC, presented instruction and sticky trap flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_misaligned  <= w_misaligned_nxt;
    end
  end

endmodule
